// File: rtl/scrambler_pkg.sv
// ----------------------------------------------------------------------------
// scrambler_pkg
// Shared types and constants for the index scrambler and its LFSR.
//   N_SLOTS / IDX_W : number of display slots and the width of a slot index
//   idx_t / perm_t  : one slot index, and a packed array of N_SLOTS indices
//   state_e         : shuffle FSM states
//   DEFAULT_*       : default LFSR seed, Galois tap mask and retry limit
// ----------------------------------------------------------------------------
package scrambler_pkg;

    localparam int N_SLOTS = 6;
    localparam int IDX_W   = 3;

    localparam logic [15:0] DEFAULT_SEED      = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS      = 16'hB400; // x^16+x^14+x^13+x^11+1
    localparam int          DEFAULT_RETRY_MAX = 7;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef idx_t [N_SLOTS-1:0] perm_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        SWAP,
        FINISH
    } state_e;

    // Slot k holds index k.
    function automatic perm_t identity_perm();
        perm_t p;
        for (int k = 0; k < N_SLOTS; k++) begin
            p[k] = idx_t'(k);
        end
        return p;
    endfunction

endpackage : scrambler_pkg

// File: rtl/index_scrambler_lfsr.sv
// ----------------------------------------------------------------------------
// galois_lfsr
// Free-running right-shifting Galois LFSR. Advances every clock; if the
// register ever holds zero it reloads SEED on the next clock so it can
// never lock up.
//   clk : system clock
//   rst : asynchronous active-low reset, loads SEED
//   q   : current LFSR value
// ----------------------------------------------------------------------------
module galois_lfsr
    import scrambler_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule : galois_lfsr

// File: rtl/index_scrambler.sv
// ----------------------------------------------------------------------------
// index_scrambler
// Produces a random permutation of display slots 0..5 on index1..index6.
// Each press of the (active-low) start button runs a Fisher-Yates shuffle
// driven by a free-running Galois LFSR; the result is published in a single
// cycle and done_scrambler is shown once the button is released.
//   clk            : system clock
//   rst            : asynchronous active-low reset
//   start          : debounced button, 0 = pressed
//   index1..index6 : destination slot for ROM digit 1..6 (always a permutation)
//   done_scrambler : result valid and button released
// Build option NO_IDENTITY_EN: when defined, an identity result is never
// published; the FSM reshuffles instead.
// ----------------------------------------------------------------------------
module index_scrambler
    import scrambler_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(DEFAULT_TAPS),
    parameter int                RETRY_MAX = DEFAULT_RETRY_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IDX_W-1:0] index1,
    output logic [IDX_W-1:0] index2,
    output logic [IDX_W-1:0] index3,
    output logic [IDX_W-1:0] index4,
    output logic [IDX_W-1:0] index5,
    output logic [IDX_W-1:0] index6,
    output logic             done_scrambler
);

    localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    // ------------------------------------------------------------------
    // Random source
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0] lfsr;
    idx_t              r;
    logic              unused_lfsr_bits;

    galois_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAPS   (TAPS)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign r                = lfsr[IDX_W-1:0];
    assign unused_lfsr_bits = ^lfsr[LFSR_W-1:IDX_W];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                start_meta_q, start_meta_d;
    logic                start_sync_q, start_sync_d;
    logic                start_prev_q, start_prev_d;
    state_e              state_q, state_d;
    perm_t               perm_q, perm_d;
    perm_t               idx_q, idx_d;
    idx_t                i_q, i_d;
    idx_t                j_q, j_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                done_q, done_d;
    logic                press;

    // Press = synchronized high-to-low transition of the button.
    assign press = start_prev_q & ~start_sync_q;

    always_comb begin
        start_meta_d = start;
        start_sync_d = start_meta_q;
        start_prev_d = start_sync_q;
        state_d      = state_q;
        perm_d       = perm_q;
        idx_d        = idx_q;
        i_d          = i_q;
        j_d          = j_q;
        retry_d      = retry_q;
        done_d       = done_q;

        unique case (state_q)
            IDLE: begin
                if (press) begin
                    done_d  = 1'b0;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                perm_d  = identity_perm();
                i_d     = idx_t'(N_SLOTS - 1);
                retry_d = '0;
                state_d = DRAW;
            end

            DRAW: begin
                // Draws above i are rejected; after RETRY_MAX rejections the
                // next rejected draw falls back to j=0 so the shuffle always
                // terminates within a bounded number of cycles.
                if (r <= i_q) begin
                    j_d     = r;
                    state_d = SWAP;
                end else if (retry_q == RETRY_W'(RETRY_MAX)) begin
                    j_d     = '0;
                    state_d = SWAP;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end

            SWAP: begin
                perm_d[i_q] = perm_q[j_q];
                perm_d[j_q] = perm_q[i_q];
                retry_d     = '0;
                if (i_q == idx_t'(1)) begin
                    state_d = FINISH;
                end else begin
                    i_d     = i_q - 1'b1;
                    state_d = DRAW;
                end
            end

            FINISH: begin
`ifdef NO_IDENTITY_EN
                // An already-solved puzzle is never handed out: reshuffle
                // from LOAD using the LFSR's advanced state.
                if (perm_q == identity_perm()) begin
                    state_d = LOAD;
                end else begin
                    idx_d   = perm_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                idx_d   = perm_q;
                done_d  = 1'b1;
                state_d = IDLE;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_meta_q <= 1'b1;
            start_sync_q <= 1'b1;
            start_prev_q <= 1'b1;
            state_q      <= IDLE;
            // NOTE: the working permutation is only six small registers, so it
            // is reset along with everything else; a reset mid-shuffle leaves
            // no partial result behind.
            perm_q       <= identity_perm();
            idx_q        <= identity_perm();
            i_q          <= '0;
            j_q          <= '0;
            retry_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            start_meta_q <= start_meta_d;
            start_sync_q <= start_sync_d;
            start_prev_q <= start_prev_d;
            state_q      <= state_d;
            perm_q       <= perm_d;
            idx_q        <= idx_d;
            i_q          <= i_d;
            j_q          <= j_d;
            retry_q      <= retry_d;
            done_q       <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign index1 = idx_q[0];
    assign index2 = idx_q[1];
    assign index3 = idx_q[2];
    assign index4 = idx_q[3];
    assign index5 = idx_q[4];
    assign index6 = idx_q[5];

    // Gated with the raw button so done drops in the same cycle as a press
    // and a stale done is never visible while the button is held.
    assign done_scrambler = done_q & start;

endmodule : index_scrambler

// File: doc/index_scrambler.md
Name: index_scrambler

Overview:
- Produces a random permutation of display slots 0..5 as index1..index6, plus the done_scrambler handshake.
- These feed the game handler's scramble step.
- Each debounced press of the start button (active-low) launches a Fisher-Yates shuffle driven by a free-running LFSR.
- Results are published atomically, and done is presented once the button is released.

Parameters:
- LFSR_W, 16, LFSR width in bits.
- SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1).
- RETRY_MAX, 7, consecutive rejected draws before fallback.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  debounced button, 0 = pressed; same signal the handler samples.
- index1..index6  out  3 each  destination slot for ROM digit 1..6; always a permutation of 0..5.
- done_scrambler  out  1  shuffle result valid and button released.

Behaviour:
- Reset (rst=0, async):
  - index1..6 = 0,1,2,3,4,5; done_q=0; state=IDLE.
  - LFSR=SEED; start synchronizer flops = 1.
- LFSR: advances every clk regardless of state. If the register is ever 0, it reloads SEED next cycle. The draw value r = LFSR[2:0].
- start passes a 2-flop synchronizer. A press is the synced 1->0 edge.
- done_scrambler = done_q AND raw start (combinational gate):
  - Drops in the same cycle start goes low.
  - Never shows stale done during a press.
- FSM:
  - IDLE: on press -> LOAD; done_q<=0.
  - LOAD: perm[k]<=k for k=0..5; i<=5; retry<=0; -> DRAW.
  - DRAW:
    - If r<=i: j<=r -> SWAP.
    - Else retry++. When retry==RETRY_MAX, j<=0 -> SWAP.
  - SWAP: exchange perm[i] and perm[j]; retry<=0.
    - If i==1 -> FINISH.
    - Else i<=i-1 -> DRAW.
  - FINISH: index1..6<=perm[0..5] in one cycle; done_q<=1; -> IDLE.
- Latency: press edge to done_q = 12 cycles minimum (LOAD + 5x(DRAW+SWAP) + FINISH). Maximum is 12+5*RETRY_MAX.
- Outputs change only in FINISH. Intermediate perm is never visible.
- A press while not in IDLE is ignored; the running shuffle completes.
- A press shorter than the shuffle: the shuffle still completes, and done appears after release.
- Reset mid-shuffle: returns to reset values immediately. The partial perm is discarded.
- Widths: i, j, r are 3-bit unsigned; compare r<=i unsigned; retry is $clog2(RETRY_MAX+1) bits.

Optional Feature:
- NO_IDENTITY_EN:
  - Defined: FINISH first checks perm == {0,1,2,3,4,5}. On a match it goes to LOAD instead (i=5 reshuffle with the advanced LFSR); outputs and done_q stay unchanged. This guarantees the player never receives an already-solved puzzle.
  - Undefined: the identity permutation is allowed and published normally.

Decomposition:
- Package scrambler_pkg:
  - N_SLOTS=6, IDX_W=3.
  - State enum: IDLE, LOAD, DRAW, SWAP, FINISH.
  - Default SEED and TAPS constants.
- Sub-module galois_lfsr (parameters LFSR_W, SEED, TAPS; ports clk, rst, q):
  - Free-running, with zero-lock recovery.
  - Reused by any later random-address logic.

Test Plan:
- Reset: hold rst=0 -> index1..6=0,1,2,3,4,5, done_scrambler=0. Release rst, no press for 100 cycles -> outputs unchanged.
- Basic shuffle: start=0 for 40 cycles, then 1 -> done_scrambler=0 throughout the press; the indices form a permutation of 0..5 and match the bit-exact C model (SEED, press edge at known cycle); done_scrambler=1 on the release cycle.
- Short press: start=0 for 3 cycles -> done_scrambler rises exactly 12+retries cycles after the synced edge. A second press 2 cycles later is ignored.
- Reset mid-shuffle: assert rst at the 6th cycle after the press edge -> done=0 and indices 0..5 immediately. The next press produces a valid permutation.
- Soak: 2000 presses at varying intervals -> each result is a valid permutation. Every value occurs in every position, with each count within 30% of the mean. No shuffle exceeds 47 cycles.
- With NO_IDENTITY_EN: force the LFSR via backdoor so the first pass yields identity -> the FSM reshuffles. The published result is not 0..5, and done is delayed by ≥11 cycles.
